fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch producer: PC, icache handshake, one-entry output buffer
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_npc
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        halt_pend_q, halt_pend_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_npc_q, out_npc_d;

    logic [31:0] target;
    logic        transfer;
    logic        accept;

    // The request stays up and the address stays put until the cache answers
    assign imemREN   = (state_q == FETCH);
    assign imemaddr  = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign out_npc   = out_npc_q;

    // Next-state: halt beats redirect, redirect beats stall; a pending
    // redirect or halt consumes the next cache hit instead of buffering it
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_v_d    = pend_v_q;
        pend_pc_d   = pend_pc_q;
        halt_pend_d = halt_pend_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_npc_d   = out_npc_q;

        target   = redirect_pc & 32'hFFFF_FFFC;
        transfer = out_valid_q && !stall;
        accept   = (state_q == FETCH) && ihit && (!out_valid_q || !stall);

        if (state_q == HALTED) begin
            out_valid_d = 1'b0;
            pend_v_d    = 1'b0;
            halt_pend_d = 1'b0;
        end else if (halt) begin
            out_valid_d = 1'b0;
            pend_v_d    = 1'b0;
            if (ihit) begin
                state_d     = HALTED;
                halt_pend_d = 1'b0;
            end else begin
                halt_pend_d = 1'b1;
            end
        end else if (halt_pend_q) begin
            out_valid_d = 1'b0;
            if (ihit) begin
                state_d     = HALTED;
                halt_pend_d = 1'b0;
            end
        end else if (redirect) begin
            out_valid_d = 1'b0;
            if (ihit) begin
                pc_d     = target;
                pend_v_d = 1'b0;
            end else begin
                pend_v_d  = 1'b1;
                pend_pc_d = target;
            end
        end else if (pend_v_q) begin
            if (transfer) begin
                out_valid_d = 1'b0;
            end
            if (ihit) begin
                pc_d     = pend_pc_q;
                pend_v_d = 1'b0;
            end
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = imemload;
            out_pc_d    = pc_q;
            out_npc_d   = pc_q + 32'd4;
            pc_d        = pc_q + 32'd4;
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops everything, including any in-flight response
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= FETCH;
            pc_q        <= PC_INIT;
            pend_v_q    <= 1'b0;
            pend_pc_q   <= 32'h0;
            halt_pend_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 32'h0;
            out_npc_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_v_q    <= pend_v_d;
            pend_pc_q   <= pend_pc_d;
            halt_pend_q <= halt_pend_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_npc_q   <= out_npc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a transaction-level reference model
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .imemload   (imemload),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_npc    (out_npc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[17:2]} ^ 32'h1234_5678;
    endfunction

    assign imemload = word_of(imemaddr);

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;

    // Scoreboard: instructions the model expects to be sitting in the buffer
    ent_t        sb[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_hwait;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        sb.delete();
        m_pend.delete();
        m_pc     = 32'h0000_0000;
        m_halted = 0;
        m_hwait  = 0;
    endtask

    // One clock of the reference: a free buffer slot plus a hit fetches the
    // next sequential instruction; control-flow events drop what is buffered
    task automatic model_step();
        bit   consumed;
        ent_t e;
        consumed = (sb.size() > 0) && !stall;
        if (m_halted) begin
        end else if (halt) begin
            sb.delete();
            m_pend.delete();
            if (ihit) m_halted = 1;
            else m_hwait = 1;
        end else if (m_hwait) begin
            if (ihit) begin
                m_halted = 1;
                m_hwait  = 0;
            end
        end else if (redirect) begin
            sb.delete();
            m_pend.delete();
            if (ihit) m_pc = redirect_pc & 32'hFFFF_FFFC;
            else m_pend.push_back(redirect_pc & 32'hFFFF_FFFC);
        end else if (m_pend.size() > 0) begin
            if (consumed) void'(sb.pop_front());
            if (ihit) m_pc = m_pend.pop_front();
        end else begin
            if (consumed) void'(sb.pop_front());
            if (ihit && sb.size() == 0) begin
                e.instr = word_of(m_pc);
                e.pc    = m_pc;
                e.npc   = m_pc + 32'd4;
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            if (nRST) model_step();
        end
    end

    // Monitor: compares the presented buffer and request against the model
    initial begin
        forever begin
            @(negedge CLK);
            if (nRST) begin
                chk("imemREN", imemREN, !m_halted);
                chk("imemaddr", imemaddr, m_pc);
                chk("out_valid", out_valid, sb.size() > 0);
                if (out_valid && sb.size() > 0) begin
                    chk("out_instr", out_instr, sb[0].instr);
                    chk("out_pc", out_pc, sb[0].pc);
                    chk("out_npc", out_npc, sb[0].npc);
                end
            end
        end
    end

    task automatic cyc(input logic ih, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic hl);
        ihit        = ih;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_imemaddr", imemaddr, 32'h0);
        chk("rst_imemREN", imemREN, 1'b1);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_npc", out_npc, 32'h0);
        model_reset();
        ihit = 0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        ihit = 0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
        @(posedge CLK);
        #1;
        do_reset();

        // Sequential fetch
        cyc(1, 0, 0, 0, 0);
        chk("t1_addr", imemaddr, 32'h4); chk("t1_pc", out_pc, 32'h0); chk("t1_npc", out_npc, 32'h4);
        cyc(1, 0, 0, 0, 0);
        chk("t1_addr", imemaddr, 32'h8); chk("t1_pc", out_pc, 32'h4);
        cyc(1, 0, 0, 0, 0);
        chk("t1_addr", imemaddr, 32'hC); chk("t1_pc", out_pc, 32'h8);

        // Back-pressure
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0);
            chk("t2_addr", imemaddr, 32'hC); chk("t2_pc", out_pc, 32'h8);
            chk("t2_valid", out_valid, 1'b1);
        end
        cyc(1, 0, 0, 0, 0);
        chk("t2_rel_pc", out_pc, 32'hC); chk("t2_rel_addr", imemaddr, 32'h10);

        // Redirect on hit
        cyc(1, 0, 1, 32'h103, 0);
        chk("t3_valid", out_valid, 1'b0); chk("t3_addr", imemaddr, 32'h100);

        // Redirect during miss, overwritten by a newer one
        cyc(1, 0, 1, 32'h20, 0);
        chk("t4_addr0", imemaddr, 32'h20);
        cyc(0, 0, 1, 32'h200, 0);
        chk("t4_hold1", imemaddr, 32'h20);
        cyc(0, 0, 1, 32'h300, 0);
        chk("t4_hold2", imemaddr, 32'h20);
        cyc(0, 0, 0, 0, 0);
        chk("t4_hold3", imemaddr, 32'h20);
        cyc(1, 0, 0, 0, 0);
        chk("t4_addr", imemaddr, 32'h300); chk("t4_valid", out_valid, 1'b0);

        // Halt during miss
        cyc(1, 0, 1, 32'h40, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t5_hold", imemaddr, 32'h40); chk("t5_ren", imemREN, 1'b1);
        cyc(0, 0, 0, 0, 0);
        chk("t5_hold2", imemaddr, 32'h40);
        cyc(1, 0, 0, 0, 0);
        chk("t5_ren_off", imemREN, 1'b0); chk("t5_valid", out_valid, 1'b0);
        cyc(1, 0, 1, 32'h500, 0);
        chk("t5_ign_ren", imemREN, 1'b0); chk("t5_ign_addr", imemaddr, 32'h40);
        chk("t5_ign_valid", out_valid, 1'b0);

        // Wrap and asynchronous reset mid-miss
        do_reset();
        cyc(1, 0, 1, 32'hFFFF_FFFE, 0);
        chk("t6_addr", imemaddr, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0);
        chk("t6_wrap", imemaddr, 32'h0); chk("t6_pc", out_pc, 32'hFFFF_FFFC);
        chk("t6_npc", out_npc, 32'h0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("t6_pre_valid", out_valid, 1'b1); chk("t6_pre_addr", imemaddr, 32'h4);
        do_reset();

        // Randomized segments, each started from reset
        for (int seg = 0; seg < 12; seg++) begin
            for (int c = 0; c < 250; c++) begin
                cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 199) == 0);
            end
            do_reset();
        end

        cyc(0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
